// File: rtl/lc2k_reg_file.sv
// Eight-entry LC2K register file: one bypassed write-back port, two registered
// read ports and a per-register pending scoreboard that stalls reads and WAW issue.
module lc2k_reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  issue_en,
    input  logic [ADDR_WIDTH-1:0] issue_dest,
    output logic                  issue_ready,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] regA_addr,
    input  logic [ADDR_WIDTH-1:0] regB_addr,
    output logic                  rd_stall,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] regA_data,
    output logic [DATA_WIDTH-1:0] regB_data,
    output logic [REG_COUNT-1:0]  pending_mask
);

    logic [DATA_WIDTH-1:0] regs_r [REG_COUNT];
    logic [REG_COUNT-1:0]  pend_eff_s;
    logic [REG_COUNT-1:0]  pend_next_s;
    logic [DATA_WIDTH-1:0] src_a_s;
    logic [DATA_WIDTH-1:0] src_b_s;
    logic                  wr_hit_s;
    logic                  issue_acc_s;
    logic                  rd_fire_s;

    // Write-back, issue acceptance and read firing qualifiers
    always_comb begin
        wr_hit_s    = wr_en && (wr_addr != {ADDR_WIDTH{1'b0}});
        issue_ready = (issue_dest == {ADDR_WIDTH{1'b0}}) || !pend_eff_s[issue_dest];
        issue_acc_s = issue_en && issue_ready && (issue_dest != {ADDR_WIDTH{1'b0}});
        rd_stall    = rd_en && (pend_eff_s[regA_addr] || pend_eff_s[regB_addr]);
        rd_fire_s   = rd_en && !rd_stall;
    end

    // Effective and next scoreboard; a same-cycle issue overrides the write-back clear
    always_comb begin
        pend_eff_s  = {REG_COUNT{1'b0}};
        pend_next_s = {REG_COUNT{1'b0}};
        for (int i = 1; i < REG_COUNT; i++) begin
            pend_eff_s[i]  = pending_mask[i] && !(wr_hit_s && (wr_addr == ADDR_WIDTH'(i)));
            pend_next_s[i] = (issue_acc_s && (issue_dest == ADDR_WIDTH'(i))) ? 1'b1 :
                             (wr_hit_s && (wr_addr == ADDR_WIDTH'(i)))       ? 1'b0 :
                             pending_mask[i];
        end
    end

    // Source operand selection with write-back bypass; r0 always reads zero
    always_comb begin
        src_a_s = {DATA_WIDTH{1'b0}};
        src_b_s = {DATA_WIDTH{1'b0}};
        if (regA_addr == {ADDR_WIDTH{1'b0}}) begin
            src_a_s = {DATA_WIDTH{1'b0}};
        end else if (wr_hit_s && (wr_addr == regA_addr)) begin
            src_a_s = wr_data;
        end else begin
            src_a_s = regs_r[regA_addr];
        end
        if (regB_addr == {ADDR_WIDTH{1'b0}}) begin
            src_b_s = {DATA_WIDTH{1'b0}};
        end else if (wr_hit_s && (wr_addr == regB_addr)) begin
            src_b_s = wr_data;
        end else begin
            src_b_s = regs_r[regB_addr];
        end
    end

    // Register array, scoreboard and read-port state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_r[i] <= {DATA_WIDTH{1'b0}};
            end
            pending_mask <= {REG_COUNT{1'b0}};
            rd_valid     <= 1'b0;
            regA_data    <= {DATA_WIDTH{1'b0}};
            regB_data    <= {DATA_WIDTH{1'b0}};
        end else begin
            if (wr_hit_s) begin
                regs_r[wr_addr] <= wr_data;
            end
            pending_mask <= pend_next_s;
            if (rd_fire_s) begin
                rd_valid  <= 1'b1;
                regA_data <= src_a_s;
                regB_data <= src_b_s;
            end else begin
                rd_valid  <= 1'b0;
            end
        end
    end

endmodule
